// File: rtl/simple_circuit_input_conditioner_if.sv
// Switch-input conditioner bus: raw pins and enable in,
// debounced levels, edge strobes and status out.
interface simple_circuit_input_conditioner_if #(
  parameter int NCH = 3
);
  logic           ena;
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] clean;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic           settled;
  logic [3:0]     chg_count;

  modport master (
    output ena,
    output raw_in,
    input  clean,
    input  rise,
    input  fall,
    input  settled,
    input  chg_count
  );

  modport slave (
    input  ena,
    input  raw_in,
    output clean,
    output rise,
    output fall,
    output settled,
    output chg_count
  );
endinterface

// File: rtl/simple_circuit_input_conditioner.sv
// Two-flop synchronizer plus per-channel counting debouncer
// feeding A/B/C, with edge strobes, settled flag and counter.
module simple_circuit_input_conditioner #(
  parameter int NCH             = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input logic clk,
  input logic rst_n,
  simple_circuit_input_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [NCH-1:0]            s1_q;
  logic [NCH-1:0]            s2_q;
  logic [NCH-1:0][CNT_W-1:0] cnt_q;
  logic [NCH-1:0][CNT_W-1:0] cnt_d;
  logic [NCH-1:0]            clean_q;
  logic [NCH-1:0]            clean_d;
  logic [NCH-1:0]            rise_q;
  logic [NCH-1:0]            rise_d;
  logic [NCH-1:0]            fall_q;
  logic [NCH-1:0]            fall_d;
  logic [3:0]                chg_q;
  logic [3:0]                chg_d;
  logic [NCH-1:0]            acc;
  logic [3:0]                nacc;
  state_e                    st [NCH];
  logic                      settled;

  // Synchronizer runs whenever out of reset, independent of ena
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.raw_in;
      s2_q <= s1_q;
    end
  end

  // Decode each channel's debounce state from its counter
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st[i] = (cnt_q[i] == '0) ? ST_STABLE : ST_PENDING;
    end
  end

  // Debounce next-state: cancel, count, or accept per channel
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    acc     = '0;
    nacc    = '0;
    for (int i = 0; i < NCH; i++) begin
      unique case (1'b1)
        !bus.ena: begin
          cnt_d[i] = '0;
        end
        bus.ena && (s2_q[i] == clean_q[i]): begin
          cnt_d[i] = '0;
        end
        bus.ena && (s2_q[i] != clean_q[i])
          && (cnt_q[i] == LAST): begin
          cnt_d[i]   = '0;
          clean_d[i] = s2_q[i];
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
          acc[i]     = 1'b1;
        end
        default: begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      endcase
    end
    for (int i = 0; i < NCH; i++) begin
      nacc = nacc + 4'(acc[i]);
    end
    chg_d = chg_q + nacc;
  end

  // Debounce state, registered strobes and transition counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      chg_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      chg_q   <= chg_d;
    end
  end

  // Settled when no channel is counting and sync agrees with clean
  always_comb begin
    settled = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if ((st[i] != ST_STABLE) || (s2_q[i] != clean_q[i])) begin
        settled = 1'b0;
      end
    end
  end

  assign bus.clean     = clean_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.settled   = settled;
  assign bus.chg_count = chg_q;

endmodule

// File: tb/tb_simple_circuit_input_conditioner.sv
// Bench for the input conditioner: window-based reference model
// checked every cycle, plus directed literal expectations.
module tb_simple_circuit_input_conditioner;

  localparam int N   = 4;
  localparam int NCH = 3;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  simple_circuit_input_conditioner_if #(.NCH(NCH)) bus ();

  simple_circuit_input_conditioner #(
    .NCH(NCH),
    .DEBOUNCE_CYCLES(N),
    .CNT_W(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: accept a level when the last N synchronized
  // samples were all taken with ena=1 and all differ from clean.
  logic [NCH-1:0] m_s1, m_s2, m_clean, m_rise, m_fall, m_pend;
  logic [3:0]     m_chg;
  logic [NCH-1:0] w_s2 [N];
  logic           w_en [N];
  bit             mvalid;

  initial mvalid = 1'b0;

  always @(posedge clk) begin : mdl
    logic [NCH-1:0] ws [N];
    logic           we [N];
    logic [NCH-1:0] c, r, f, p;
    logic [3:0]     g;
    bit             all;
    if (!rst_n) begin
      m_s1    <= '0;
      m_s2    <= '0;
      m_clean <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
      m_pend  <= '0;
      m_chg   <= '0;
      for (int k = 0; k < N; k++) begin
        w_s2[k] <= '0;
        w_en[k] <= 1'b0;
      end
      mvalid <= 1'b1;
    end else begin
      for (int k = N - 1; k > 0; k--) begin
        ws[k] = w_s2[k-1];
        we[k] = w_en[k-1];
      end
      ws[0] = m_s2;
      we[0] = bus.ena;
      c = m_clean;
      r = '0;
      f = '0;
      p = '0;
      g = m_chg;
      for (int ch = 0; ch < NCH; ch++) begin
        all = 1'b1;
        for (int k = 0; k < N; k++) begin
          if (!(we[k] && (ws[k][ch] != m_clean[ch]))) all = 1'b0;
        end
        p[ch] = we[0] && (ws[0][ch] != m_clean[ch]) && !all;
        if (all) begin
          c[ch] = ~m_clean[ch];
          if (c[ch]) r[ch] = 1'b1;
          else f[ch] = 1'b1;
          g = g + 4'd1;
        end
      end
      for (int k = 0; k < N; k++) begin
        w_s2[k] <= ws[k];
        w_en[k] <= we[k];
      end
      m_clean <= c;
      m_rise  <= r;
      m_fall  <= f;
      m_pend  <= p;
      m_chg   <= g;
      m_s2    <= m_s1;
      m_s1    <= bus.raw_in;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", nm, got, exp);
  endtask

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_clean", int'(bus.clean), int'(m_clean));
      chk("m_rise", int'(bus.rise), int'(m_rise));
      chk("m_fall", int'(bus.fall), int'(m_fall));
      chk("m_chg", int'(bus.chg_count), int'(m_chg));
      chk("m_settled", int'(bus.settled),
          int'((m_pend == '0) && (m_s2 == m_clean)));
      chk("rise_fall_excl", int'(bus.rise & bus.fall), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.raw_in = 3'b111;

    // Reset with all inputs high
    tick(2);
    chk("rst_clean", int'(bus.clean), 0);
    chk("rst_rise", int'(bus.rise), 0);
    chk("rst_fall", int'(bus.fall), 0);
    chk("rst_chg", int'(bus.chg_count), 0);
    chk("rst_settled", int'(bus.settled), 1);
    rst_n = 1'b1;
    tick(5);
    chk("rel_clean5", int'(bus.clean), 0);
    tick(1);
    chk("rel_clean6", int'(bus.clean), 7);
    chk("rel_rise6", int'(bus.rise), 7);
    chk("rel_chg6", int'(bus.chg_count), 3);
    tick(1);
    chk("rel_rise7", int'(bus.rise), 0);
    chk("rel_settled7", int'(bus.settled), 1);

    // Bounce on channel 0 is rejected
    bus.raw_in = 3'b110;
    tick(10);
    chk("b_pre_clean", int'(bus.clean), 6);
    chk("b_pre_chg", int'(bus.chg_count), 4);
    bus.raw_in = 3'b111; tick(1);
    bus.raw_in = 3'b110; tick(1);
    bus.raw_in = 3'b111; tick(1);
    bus.raw_in = 3'b110; tick(10);
    chk("b_clean", int'(bus.clean), 6);
    chk("b_chg", int'(bus.chg_count), 4);

    // Clean edge latency on channel 2
    bus.raw_in = 3'b010;
    tick(10);
    chk("l_pre_clean", int'(bus.clean), 2);
    bus.raw_in = 3'b110;
    tick(2);
    chk("l_settled_k1", int'(bus.settled), 0);
    tick(3);
    chk("l_clean_k4", int'(bus.clean), 2);
    chk("l_settled_k4", int'(bus.settled), 0);
    tick(1);
    chk("l_clean_k5", int'(bus.clean), 6);
    chk("l_rise_k5", int'(bus.rise), 4);
    chk("l_chg_k5", int'(bus.chg_count), 6);
    tick(1);
    chk("l_rise_k6", int'(bus.rise), 0);
    chk("l_settled_k6", int'(bus.settled), 1);

    // Enable freeze
    bus.raw_in = 3'b000;
    tick(10);
    chk("e_pre_chg", int'(bus.chg_count), 8);
    bus.ena    = 1'b0;
    bus.raw_in = 3'b101;
    tick(20);
    chk("e_hold_clean", int'(bus.clean), 0);
    chk("e_hold_chg", int'(bus.chg_count), 8);
    bus.ena = 1'b1;
    tick(3);
    chk("e_clean3", int'(bus.clean), 0);
    tick(1);
    chk("e_clean4", int'(bus.clean), 5);
    chk("e_chg4", int'(bus.chg_count), 10);

    // Counter wrap: 16 toggles leave count unchanged
    for (int t = 0; t < 16; t++) begin
      bus.raw_in[0] = ~bus.raw_in[0];
      tick(7);
    end
    chk("w_chg16", int'(bus.chg_count), 10);
    for (int t = 0; t < 4; t++) begin
      bus.raw_in[0] = ~bus.raw_in[0];
      tick(7);
    end
    chk("w_chg14", int'(bus.chg_count), 14);
    bus.raw_in = 3'b010;
    tick(7);
    chk("w_chg_wrap", int'(bus.chg_count), 1);
    chk("w_clean", int'(bus.clean), 2);

    // Reset during a pending change
    bus.raw_in = 3'b111;
    tick(4);
    chk("r_pending_settled", int'(bus.settled), 0);
    rst_n = 1'b0;
    tick(1);
    chk("r_clean", int'(bus.clean), 0);
    chk("r_chg", int'(bus.chg_count), 0);
    chk("r_settled", int'(bus.settled), 1);
    rst_n = 1'b1;
    tick(5);
    chk("r_clean5", int'(bus.clean), 0);
    tick(1);
    chk("r_clean6", int'(bus.clean), 7);
    chk("r_chg6", int'(bus.chg_count), 3);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
